// File: rtl/alu_sequencer_pkg.sv
// Shared constants for the ALU sequencer: opcodes, FSM states, ALU select codes, IR fields.
// Optional macro ALU_SEQ_CMP_EN makes opcode 8 a compare (SUB without write-back).
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_e;

  localparam logic [3:0] OP_MV  = 4'd0;
  localparam logic [3:0] OP_ADD = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_AND = 4'd3;
  localparam logic [3:0] OP_LSL = 4'd4;
  localparam logic [3:0] OP_LSR = 4'd5;
  localparam logic [3:0] OP_ASR = 4'd6;
  localparam logic [3:0] OP_ROR = 4'd7;
  localparam logic [3:0] OP_CMP = 4'd8;

  // ALU select packing: {barrel_shift[2:0], and_signal, add_sub}
  localparam logic [4:0] SEL_NONE = 5'b00000;
  localparam logic [4:0] SEL_ADD  = 5'b00001;
  localparam logic [4:0] SEL_SUB  = 5'b00000;
  localparam logic [4:0] SEL_AND  = 5'b00010;
  localparam logic [4:0] SEL_LSL  = 5'b00100;
  localparam logic [4:0] SEL_LSR  = 5'b01000;
  localparam logic [4:0] SEL_ASR  = 5'b01100;
  localparam logic [4:0] SEL_ROR  = 5'b10000;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;
  localparam int RX_MSB  = 11;
  localparam int RX_LSB  = 9;
  localparam int I_BIT   = 8;
  localparam int IMM_MSB = 7;
  localparam int RY_MSB  = 2;
  localparam int RY_LSB  = 0;

  function automatic logic is_cmp(input logic [3:0] op);
`ifdef ALU_SEQ_CMP_EN
    return (op == OP_CMP);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic is_alu(input logic [3:0] op);
    return ((op >= OP_ADD) && (op <= OP_ROR)) || is_cmp(op);
  endfunction

  function automatic logic [4:0] alu_sel(input logic [3:0] op);
    logic [4:0] sel;
    sel = SEL_NONE;
    case (op)
      OP_ADD:  sel = SEL_ADD;
      OP_SUB:  sel = SEL_SUB;
      OP_AND:  sel = SEL_AND;
      OP_LSL:  sel = SEL_LSL;
      OP_LSR:  sel = SEL_LSR;
      OP_ASR:  sel = SEL_ASR;
      OP_ROR:  sel = SEL_ROR;
      OP_CMP:  sel = SEL_SUB;
      default: sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_sequencer_dec3to8.sv
// 3-to-8 one-hot decoder with enable; drives the register bus enables.
module dec3to8 (
  input  logic       en_i,
  input  logic [2:0] sel_i,
  output logic [7:0] onehot_o
);

  assign onehot_o = en_i ? (8'b0000_0001 << sel_i) : 8'b0000_0000;

endmodule

// File: rtl/alu_sequencer.sv
// Four-state instruction sequencer producing register/ALU bus controls from a 16-bit IR.
// Optional macro ALU_SEQ_CMP_EN (via package) enables opcode 8 as compare.
//
// state | meaning
// T0    | idle; capture instr into IR when run is high
// T1    | MV completes / ALU loads operand A from rX / illegal completes
// T2    | ALU operand source to bus, result loaded into G
// T3    | G written back to rX (skipped for compare), instruction completes
module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic [15:0] instr_in_i,
  output logic        done_o,
  output logic        illegal_o,
  output logic [7:0]  r_out_o,
  output logic [7:0]  r_in_o,
  output logic        imm_out_o,
  output logic [15:0] imm_data_o,
  output logic        a_load_o,
  output logic        g_load_o,
  output logic        g_out_o,
  output logic        add_sub_o,
  output logic        and_signal_o,
  output logic [2:0]  barrel_shift_o
);

  state_e      state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic        rout_en, rin_en;
  logic [2:0]  rout_sel, rin_sel;
  logic [4:0]  sel;

  logic [3:0] opc;
  logic [2:0] rx, ry;
  logic       imm_mode;

  assign opc      = ir_q[OPC_MSB:OPC_LSB];
  assign rx       = ir_q[RX_MSB:RX_LSB];
  assign ry       = ir_q[RY_MSB:RY_LSB];
  assign imm_mode = ir_q[I_BIT];

  assign ir_d = (state_q == T0 && run_i) ? instr_in_i : ir_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= T0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      T0: state_d = run_i ? T1 : T0;
      T1: state_d = is_alu(opc) ? T2 : T0;
      T2: state_d = T3;
      T3: state_d = T0;
      default: state_d = T0;
    endcase
  end

  always_comb begin
    done_o    = 1'b0;
    illegal_o = 1'b0;
    imm_out_o = 1'b0;
    a_load_o  = 1'b0;
    g_load_o  = 1'b0;
    g_out_o   = 1'b0;
    rout_en   = 1'b0;
    rout_sel  = 3'd0;
    rin_en    = 1'b0;
    rin_sel   = 3'd0;
    sel       = SEL_NONE;
    case (state_q)
      T1: begin
        if (opc == OP_MV) begin
          imm_out_o = imm_mode;
          rout_en   = ~imm_mode;
          rout_sel  = ry;
          rin_en    = 1'b1;
          rin_sel   = rx;
          done_o    = 1'b1;
        end else if (is_alu(opc)) begin
          rout_en  = 1'b1;
          rout_sel = rx;
          a_load_o = 1'b1;
        end else begin
          done_o    = 1'b1;
          illegal_o = 1'b1;
        end
      end
      T2: begin
        imm_out_o = imm_mode;
        rout_en   = ~imm_mode;
        rout_sel  = ry;
        g_load_o  = 1'b1;
        sel       = alu_sel(opc);
      end
      T3: begin
        // Compare keeps G off the bus so the flags path sees the result without write-back.
        g_out_o = ~is_cmp(opc);
        rin_en  = ~is_cmp(opc);
        rin_sel = rx;
        done_o  = 1'b1;
      end
      default: ;
    endcase
  end

  assign {barrel_shift_o, and_signal_o, add_sub_o} = sel;
  assign imm_data_o = {8'h00, ir_q[IMM_MSB:0]};

  dec3to8 u_dec_rout (
    .en_i     (rout_en),
    .sel_i    (rout_sel),
    .onehot_o (r_out_o)
  );

  dec3to8 u_dec_rin (
    .en_i     (rin_en),
    .sel_i    (rin_sel),
    .onehot_o (r_in_o)
  );

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed self-checking bench for alu_sequencer; follows ALU_SEQ_CMP_EN for opcode 8.
module tb_alu_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] instr;
  logic        done, illegal, imm_out, a_load, g_load, g_out, add_sub, and_s;
  logic [7:0]  r_out, r_in;
  logic [15:0] imm_data;
  logic [2:0]  barrel;
  logic [26:0] ctl;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  alu_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .run_i          (run),
    .instr_in_i     (instr),
    .done_o         (done),
    .illegal_o      (illegal),
    .r_out_o        (r_out),
    .r_in_o         (r_in),
    .imm_out_o      (imm_out),
    .imm_data_o     (imm_data),
    .a_load_o       (a_load),
    .g_load_o       (g_load),
    .g_out_o        (g_out),
    .add_sub_o      (add_sub),
    .and_signal_o   (and_s),
    .barrel_shift_o (barrel)
  );

  assign ctl = {done, illegal, r_out, r_in, imm_out, a_load, g_load, g_out, barrel, and_s, add_sub};

  function automatic logic [26:0] mk(input logic dn, input logic il, input logic [7:0] ro,
                                     input logic [7:0] ri, input logic im, input logic al,
                                     input logic gl, input logic go, input logic [4:0] sl);
    return {dn, il, ro, ri, im, al, gl, go, sl};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [26:0] e);
    logic [3:0] drivers;
    drivers = 4'($countones(r_out)) + 4'(imm_out) + 4'(g_out);
    chk(tag, 32'(ctl), 32'(e));
    chk({tag, "_onedrv"}, 32'(drivers <= 4'd1), 32'd1);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  // Full ALU instruction with hand-computed expectations; run held as given.
  task automatic alu_instr(input string tag, input logic [15:0] iw, input logic run_hold,
                           input logic [7:0] ra, input logic [7:0] rb, input logic imm_b,
                           input logic [4:0] sl, input logic wb);
    run = 1'b1; instr = iw; #1;
    step({tag, "_t0"}, '0);
    nxt(); run = run_hold; instr = 16'hFFFF; #1;
    step({tag, "_t1"}, mk(0, 0, ra, 8'h00, 0, 1, 0, 0, 5'b00000));
    nxt(); #1;
    step({tag, "_t2"}, mk(0, 0, rb, 8'h00, imm_b, 0, 1, 0, sl));
    nxt(); #1;
    step({tag, "_t3"}, mk(1, 0, 8'h00, wb ? ra : 8'h00, 0, 0, 0, wb, 5'b00000));
    nxt();
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; instr = 16'h0000;
    #2;
    step("reset", '0);
    chk("reset_imm", 32'(imm_data), 32'h0);
    nxt(); rst = 1'b0;

    // ADD R1,R5
    alu_instr("add", 16'h1205, 1'b0, 8'h02, 8'h20, 1'b0, 5'b00001, 1'b1);
    #1; step("add_idle", '0);

    // MV R7,#0x2A : done in the cycle after run
    run = 1'b1; instr = 16'h0F2A; #1;
    step("mv_t0", '0);
    nxt(); run = 1'b0; #1;
    step("mv_t1", mk(1, 0, 8'h00, 8'h80, 1, 0, 0, 0, 5'b00000));
    chk("mv_imm", 32'(imm_data), 32'h002A);
    nxt(); #1;
    step("mv_idle", '0);

    // ROR R3,R0 then ASR R3,#4 with run held high throughout
    alu_instr("ror", 16'h7600, 1'b1, 8'h08, 8'h01, 1'b0, 5'b10000, 1'b1);
    alu_instr("asr", 16'h6704, 1'b1, 8'h08, 8'h00, 1'b1, 5'b01100, 1'b1);
    chk("asr_imm", 32'(imm_data), 32'h0004);
    run = 1'b0; #1;
    step("asr_idle", '0);

    alu_instr("and", 16'h3305, 1'b0, 8'h02, 8'h00, 1'b1, 5'b00010, 1'b1);
    alu_instr("lsl", 16'h4201, 1'b0, 8'h02, 8'h02, 1'b0, 5'b00100, 1'b1);
    alu_instr("lsr", 16'h5201, 1'b0, 8'h02, 8'h02, 1'b0, 5'b01000, 1'b1);

    // Undefined opcode 0xF
    run = 1'b1; instr = 16'hF3FF; nxt(); run = 1'b0; #1;
    step("ill_t1", mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 5'b00000));
    nxt(); #1;
    step("ill_idle", '0);

    // Opcode 8
`ifdef ALU_SEQ_CMP_EN
    alu_instr("cmp", 16'h8205, 1'b0, 8'h02, 8'h20, 1'b0, 5'b00000, 1'b0);
`else
    run = 1'b1; instr = 16'h8205; nxt(); run = 1'b0; #1;
    step("op8_t1", mk(1, 1, 8'h00, 8'h00, 0, 0, 0, 0, 5'b00000));
    nxt();
`endif
    #1; step("op8_idle", '0);

    // SUB R1,R5 interrupted by reset in T2
    run = 1'b1; instr = 16'h2205; nxt(); run = 1'b0; #1;
    step("sub_t1", mk(0, 0, 8'h02, 8'h00, 0, 1, 0, 0, 5'b00000));
    nxt(); #1;
    step("sub_t2", mk(0, 0, 8'h20, 8'h00, 0, 0, 1, 0, 5'b00000));
    chk("sub_imm_pre", 32'(imm_data), 32'h0005);
    #1; rst = 1'b1; #1;
    step("sub_rst_async", '0);
    chk("sub_rst_imm", 32'(imm_data), 32'h0);
    nxt(); rst = 1'b0; #1;
    step("post_rst_0", '0);
    nxt(); #1;
    step("post_rst_1", '0);
    nxt(); #1;
    step("post_rst_2", '0);

    // Sequencer still works after the abort
    alu_instr("add2", 16'h1E03, 1'b0, 8'h80, 8'h08, 1'b0, 5'b00001, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Clock  input  1  single clock; all state updates on its rising edge.
REQ-002 Reset  input  1  asynchronous, active-high reset.
REQ-003 Run  input  1  start request; sampled only in state T0.
REQ-004 instr_in  input  16  instruction word, captured into IR when Run=1 in T0.
REQ-005 Done  output  1  one-cycle pulse in the final state of every instruction.
REQ-006 illegal  output  1  pulses with Done for an undefined opcode.
REQ-007 R_out  output  8  one-hot register-to-bus drive enable.
REQ-008 R_in  output  8  one-hot bus-to-register load enable.
REQ-009 imm_out, imm_data  output  1, 16  immediate bus drive enable and the zero-extended IR[7:0].
REQ-010 A_load, G_load, G_out  output  1 each  operand-A load, result-register load, result-to-bus drive.
REQ-011 add_sub, and_signal, barrel_shift  output  1, 1, 3  ALU operation select: {barrel_shift, and_signal, add_sub}.

Function
REQ-012 IR format SHALL be: opcode IR[15:12], rX IR[11:9], I IR[8], rY IR[2:0] when I=0, imm IR[7:0] when I=1.
REQ-013 Opcodes SHALL be 0 MV, 1 ADD, 2 SUB, 3 AND, 4 LSL, 5 LSR, 6 ASR, 7 ROR; all other opcodes are illegal (see REQ-027 for 8).
REQ-014 The FSM SHALL have states T0 (idle/fetch), T1, T2, T3; T0->T1 when Run=1, otherwise it stays in T0.
REQ-015 The operand source SHALL be: when I=0, R_out one-hot on rY; when I=1, imm_out=1.
REQ-016 MV in T1: drive the operand source, R_in one-hot on rX, Done=1, then return to T0; latency is 2 cycles from Run.
REQ-017 ALU op in T1: R_out one-hot on rX, A_load=1.
REQ-018 ALU op in T2: drive the operand source, G_load=1, and drive the ALU select per REQ-019.
REQ-019 ALU select in T2 SHALL be: ADD 00001, SUB 00000, AND 00010, LSL 00100, LSR 01000, ASR 01100, ROR 10000.
REQ-020 ALU op in T3: G_out=1, R_in one-hot on rX, Done=1, then return to T0; latency is 4 cycles from Run.
REQ-021 Illegal opcode in T1: Done=1, illegal=1, no bus drive and no load, then return to T0.
REQ-022 Outside the state or opcode that requires them, all control outputs SHALL be 0; ALU select SHALL be 00000.
REQ-023 At most one bus driver (R_out bit, imm_out, G_out) SHALL be active in any cycle.
REQ-024 Run asserted outside T0 SHALL be ignored; IR SHALL remain stable from T1 until return to T0.
REQ-025 Back-to-back instructions: with Run held high in the T0 following Done, the next IR SHALL be captured with no bubble.

Reset
REQ-026 On Reset: state=T0, IR=0, every output=0; this applies immediately, including mid-instruction, and no partial write SHALL complete.

Configuration
REQ-027 With ALU_SEQ_CMP_EN defined, opcode 8 = CMP: T1/T2 as SUB, T3 with G_out=0, R_in=0, Done=1; without the macro, opcode 8 is illegal per REQ-021.

Structure
REQ-028 A shared package SHALL hold opcode constants, the state enum, ALU select encodings, and IR field positions.
REQ-029 A sub-module dec3to8 (3-bit to one-hot 8-bit with enable) SHALL generate R_out and R_in.

Verification
REQ-030 Reset, then Run with instr_in=0x1205 (ADD R1,R5) -> T1 R_out=0x02, A_load; T2 R_out=0x20, G_load, select 00001; T3 G_out, R_in=0x02, Done.
REQ-031 instr_in=0x0F2A (MV R7,#0x2A) -> T1 imm_out=1, imm_data=0x002A, R_in=0x80, Done; total latency 2 cycles.
REQ-032 ROR R3,R0 (0x7600) then back-to-back ASR R3,#4 (0x6704) -> select 10000 then 01100; Done pulses at cycles 4 and 8.
REQ-033 Opcode 0xF -> Done=1 and illegal=1 in T1, no bus driver active; opcode 8 behaves as CMP or as illegal depending on ALU_SEQ_CMP_EN.
REQ-034 Reset asserted during T2 of SUB -> outputs 0 asynchronously, G_load drops, no R_in pulse follows; Run pulses during T1–T3 are ignored.
